// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALU opcodes and condition-code bit positions
package alu_operand_stage_pkg;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam int OP_W     = 4;
   localparam int CC_W     = 4;
   typedef enum logic [OP_W-1:0] {
      OP_PASSA = 4'b0000,
      OP_INCA  = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_ADDC1 = 4'b0011,
      OP_SUBB1 = 4'b0100,
      OP_SUBC  = 4'b0101,
      OP_DECA  = 4'b0110,
      OP_PASSB = 4'b0111
   } alu_op_e;
   localparam int CC_Z = 3;
   localparam int CC_C = 2;
   localparam int CC_N = 1;
   localparam int CC_V = 0;
endpackage

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// regfile_2r1w: general register file with two combinational reads and one synchronous write
module regfile_2r1w
   import alu_operand_stage_pkg::*;
#(
   parameter int NREGS = NUM_REGS,
   parameter int WIDTH = DATA_W
) (
   input  logic                     clock,
   input  logic                     reset_L,
   input  logic [$clog2(NREGS)-1:0] rd_idx_a,
   output logic [WIDTH-1:0]         rd_data_a,
   input  logic [$clog2(NREGS)-1:0] rd_idx_b,
   output logic [WIDTH-1:0]         rd_data_b,
   input  logic                     wr_en,
   input  logic [$clog2(NREGS)-1:0] wr_idx,
   input  logic [WIDTH-1:0]         wr_data
);
   logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
   assign rd_data_a = regs_q[rd_idx_a];
   assign rd_data_b = regs_q[rd_idx_b];
   // next register contents: only the addressed entry changes on a write
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_idx] = wr_data;
   end
   // register array, cleared to zero on reset (R0 included, it is writable)
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) regs_q <= '0;
      else          regs_q <= regs_d;
   end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with write-back bypass, single-entry operand buffer and CC register
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int NREGS = NUM_REGS,
   parameter int WIDTH = DATA_W
) (
   input  logic                     clock,
   input  logic                     reset_L,
   input  logic                     iss_valid,
   output logic                     iss_ready,
   input  logic [$clog2(NREGS)-1:0] srcA,
   input  logic [$clog2(NREGS)-1:0] srcB,
   input  logic                     useImm,
   input  logic [WIDTH-1:0]         imm,
   input  logic [OP_W-1:0]          op_in,
   output logic                     op_valid,
   input  logic                     op_ready,
   output logic [WIDTH-1:0]         inA,
   output logic [WIDTH-1:0]         inB,
   output logic [OP_W-1:0]          ALUop,
   input  logic                     wb_en,
   input  logic [$clog2(NREGS)-1:0] wb_dst,
   input  logic [WIDTH-1:0]         wb_data,
   input  logic                     cc_load,
   input  logic [CC_W-1:0]          CCin,
   output logic [CC_W-1:0]          CC
);
   logic [WIDTH-1:0] rf_a, rf_b, byp_a, byp_b;
   logic [WIDTH-1:0] in_a_q, in_a_d, in_b_q, in_b_d;
   alu_op_e          op_q, op_d;
   logic             op_valid_q, op_valid_d;
   logic [CC_W-1:0]  cc_q, cc_d;
   logic             accept;
   regfile_2r1w #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
      .clock     (clock),
      .reset_L   (reset_L),
      .rd_idx_a  (srcA),
      .rd_data_a (rf_a),
      .rd_idx_b  (srcB),
      .rd_data_b (rf_b),
      .wr_en     (wb_en),
      .wr_idx    (wb_dst),
      .wr_data   (wb_data)
   );
   // ready depends only on buffer state and the consumer, never on iss_valid
   assign iss_ready = ~op_valid_q | op_ready;
   assign accept    = iss_valid & iss_ready;
   assign op_valid  = op_valid_q;
   assign inA       = in_a_q;
   assign inB       = in_b_q;
   assign ALUop     = op_q;
   assign CC        = cc_q;
   // bypass same-cycle write-back into the fetch; buffer loads only on accept so stalled operands stay stale
   always_comb begin
      byp_a      = (wb_en && wb_dst == srcA) ? wb_data : rf_a;
      byp_b      = (wb_en && wb_dst == srcB) ? wb_data : rf_b;
      in_a_d     = accept ? byp_a : in_a_q;
      in_b_d     = accept ? (useImm ? imm : byp_b) : in_b_q;
      op_d       = accept ? alu_op_e'(op_in) : op_q;
      op_valid_d = accept | (op_valid_q & ~op_ready);
   end
   // condition codes load as a whole word from the ALU, flag by flag with no masking
   always_comb begin
      cc_d       = cc_q;
      cc_d[CC_Z] = cc_load ? CCin[CC_Z] : cc_q[CC_Z];
      cc_d[CC_C] = cc_load ? CCin[CC_C] : cc_q[CC_C];
      cc_d[CC_N] = cc_load ? CCin[CC_N] : cc_q[CC_N];
      cc_d[CC_V] = cc_load ? CCin[CC_V] : cc_q[CC_V];
   end
   // operand buffer and CC state; reset drops any in-flight op
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         op_valid_q <= 1'b0;
         in_a_q     <= '0;
         in_b_q     <= '0;
         op_q       <= OP_PASSA;
         cc_q       <= '0;
      end else begin
         op_valid_q <= op_valid_d;
         in_a_q     <= in_a_d;
         in_b_q     <= in_b_d;
         op_q       <= op_d;
         cc_q       <= cc_d;
      end
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with a scoreboard queue checked by a separate monitor
module tb_alu_operand_stage;
   logic        clock = 1'b0;
   logic        reset_L;
   logic        iss_valid, iss_ready;
   logic [2:0]  srcA, srcB;
   logic        useImm;
   logic [15:0] imm;
   logic [3:0]  op_in;
   logic        op_valid, op_ready;
   logic [15:0] inA, inB;
   logic [3:0]  ALUop;
   logic        wb_en;
   logic [2:0]  wb_dst;
   logic [15:0] wb_data;
   logic        cc_load;
   logic [3:0]  CCin, CC;
   logic [35:0] sb_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   alu_operand_stage dut (
      .clock(clock), .reset_L(reset_L), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .srcA(srcA), .srcB(srcB), .useImm(useImm), .imm(imm), .op_in(op_in),
      .op_valid(op_valid), .op_ready(op_ready), .inA(inA), .inB(inB), .ALUop(ALUop),
      .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
      .cc_load(cc_load), .CCin(CCin), .CC(CC)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      iss_valid = 0; wb_en = 0; cc_load = 0; useImm = 0;
      srcA = 0; srcB = 0; imm = 0; op_in = 0; wb_dst = 0; wb_data = 0; CCin = 0;
   endtask

   task automatic wb(input logic [2:0] d, input logic [15:0] v);
      wb_en = 1; wb_dst = d; wb_data = v;
   endtask

   task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic ui,
                        input logic [15:0] im, input logic [3:0] op,
                        input logic [15:0] exp_a, input logic [15:0] exp_b);
      iss_valid = 1; srcA = a; srcB = b; useImm = ui; imm = im; op_in = op;
      sb_q.push_back({exp_a, exp_b, op});
   endtask

   // monitor: every consumed op is compared against the oldest expected entry
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clock);
         if (reset_L && op_valid && op_ready) begin
            if (sb_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_op: got inA=%h inB=%h op=%h, expected no op", inA, inB, ALUop);
            end else begin
               e = sb_q.pop_front();
               chk("sb_inA", inA, e[35:20]);
               chk("sb_inB", inB, e[19:4]);
               chk("sb_ALUop", {12'h0, ALUop}, {12'h0, e[3:0]});
            end
         end
      end
   end

   initial begin
      idle();
      op_ready = 1;
      reset_L  = 0;
      #12;
      chk("rst_op_valid", {15'h0, op_valid}, 16'h0);
      chk("rst_CC", {12'h0, CC}, 16'h0);
      chk("rst_inA", inA, 16'h0);
      chk("rst_inB", inB, 16'h0);
      chk("rst_ALUop", {12'h0, ALUop}, 16'h0);
      chk("rst_iss_ready", {15'h0, iss_ready}, 16'h1);
      reset_L = 1;
      // write then read
      wb(3, 16'h1234); tick(); idle();
      issue(3, 3, 0, 16'h0, 4'h0, 16'h1234, 16'h1234); tick(); idle();
      chk("wr_rd_op_valid", {15'h0, op_valid}, 16'h1);
      // bypass on A with immediate B, then bypass on B, then non-matching write-back
      wb(5, 16'hBEEF); issue(5, 0, 1, 16'h0001, 4'h2, 16'hBEEF, 16'h0001); tick(); idle();
      wb(6, 16'h6666); issue(3, 6, 0, 16'h0, 4'h7, 16'h1234, 16'h6666); tick(); idle();
      wb(1, 16'h1111); issue(3, 5, 0, 16'h0, 4'h3, 16'h1234, 16'hBEEF); tick(); idle();
      // R0 is writable
      wb(0, 16'hA5A5); tick(); idle();
      issue(0, 1, 0, 16'h0, 4'h4, 16'hA5A5, 16'h1111); tick(); idle();
      wb(2, 16'h0022); tick(); idle();
      tick();
      chk("drained_op_valid", {15'h0, op_valid}, 16'h0);
      // backpressure with a stale-operand write-back during the stall
      op_ready = 0;
      issue(2, 0, 0, 16'h0, 4'h5, 16'h0022, 16'hA5A5); tick(); idle();
      iss_valid = 1; srcA = 6; srcB = 3; op_in = 4'h6;
      for (int i = 0; i < 5; i++) begin
         chk("stall_iss_ready", {15'h0, iss_ready}, 16'h0);
         chk("stall_op_valid", {15'h0, op_valid}, 16'h1);
         chk("stall_inA", inA, 16'h0022);
         chk("stall_inB", inB, 16'hA5A5);
         chk("stall_ALUop", {12'h0, ALUop}, 16'h5);
         if (i == 0) wb(2, 16'hFFFF);
         else wb_en = 0;
         tick();
      end
      chk("stale_inA", inA, 16'h0022);
      op_ready = 1;
      issue(2, 3, 0, 16'h0, 4'h6, 16'hFFFF, 16'h1234); tick(); idle();
      chk("nobubble_op_valid", {15'h0, op_valid}, 16'h1);
      chk("nobubble_inA", inA, 16'hFFFF);
      tick();
      // condition codes
      cc_load = 1; CCin = 4'b1010;
      chk("cc_not_comb", {12'h0, CC}, 16'h0);
      tick();
      chk("cc_load", {12'h0, CC}, 16'hA);
      cc_load = 0; CCin = 4'b0101; tick();
      chk("cc_hold", {12'h0, CC}, 16'hA);
      cc_load = 1; tick(); idle();
      chk("cc_reload", {12'h0, CC}, 16'h5);
      // mid-stream reset with all registers nonzero
      wb(4, 16'h4444); tick(); wb(7, 16'h7777); tick(); idle();
      op_ready = 0;
      issue(7, 4, 0, 16'h0, 4'h1, 16'h7777, 16'h4444); tick(); idle();
      chk("pre_rst_op_valid", {15'h0, op_valid}, 16'h1);
      #2;
      reset_L = 0;
      sb_q.delete();
      #1;
      chk("mid_rst_op_valid", {15'h0, op_valid}, 16'h0);
      chk("mid_rst_CC", {12'h0, CC}, 16'h0);
      chk("mid_rst_inA", inA, 16'h0);
      #3;
      reset_L = 1;
      op_ready = 1;
      for (int i = 0; i < 8; i++) begin
         issue(3'(i), 3'(i), 0, 16'h0, 4'(i), 16'h0, 16'h0);
         tick();
      end
      idle();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
      chk("sb_drained", 16'(sb_q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
